// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end feeding one bit-serial adder.
// One operation takes WIDTH RUN cycles plus a DONE cycle that can overlap the next grant.
module serial_add_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic             last;
  logic             id;

  logic             win;
  logic             s_bit;
  logic             c_next;
  logic             ovf_next;
  logic [WIDTH-1:0] sum_next;

  // NOTE: gnt is decoded combinationally; defaults first keep this block latch-free,
  // and gating with rstn keeps requests from being considered while in reset.
  always_comb begin
    gnt = 2'b00;
    if (rstn && state != RUN) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    win = gnt[1];
  end

  // Single full adder; on the last step a_sh[0]/b_sh[0] hold the operand MSBs.
  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    sum_next = {s_bit, acc};
    ovf_next = (a_sh[0] == b_sh[0]) && (s_bit != a_sh[0]);
  end

  // NOTE: every register, datapath included, is reset so an aborted operation
  // leaves no stale carry or partial sum behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      last  <= 1'b1;  // requester 1 "served last" gives requester 0 first priority
      id    <= 1'b0;
      done  <= 2'b00;
      busy  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 2'b00;
      unique case (state)
        IDLE, DONE: begin
          if (|gnt) begin
            a_sh  <= win ? a1 : a0;
            b_sh  <= win ? b1 : b0;
            carry <= 1'b0;
            cnt   <= '0;
            id    <= win;
            last  <= win;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= sum_next[WIDTH-1:1];
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= id ? 2'b10 : 2'b01;
            sum   <= sum_next;
            cout  <= c_next;
            zero  <= (sum_next == '0);
            ovf   <= ovf_next;
            neg   <= s_bit ^ ovf_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: random and directed stimulus against a
// transaction-level model (integer add, signed range test, cycle-numbered schedule).
module tb_serial_add_arbiter;

  localparam int W  = 6;
  localparam int BW = W + 9;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt, done;
  logic [W-1:0] sum;
  logic         cout, zero, neg, ovf, busy;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done), .sum(sum),
    .cout(cout), .zero(zero), .neg(neg), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: an op granted in cycle n completes (done) in cycle n+W+1; new grants
  // are possible in any cycle at or after the current op's done cycle.
  int           m_done_cyc;
  logic         m_last;
  logic         m_id;
  logic [W+3:0] pend, vis;   // {sum, cout, zero, neg, ovf}
  logic [1:0]   exp_gnt, exp_done;
  logic         exp_busy;

  logic [BW-1:0] obs;
  assign obs = {gnt, done, busy, sum, cout, zero, neg, ovf};

  function automatic logic [W+3:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, us, sa, sb, ts;
    logic [W-1:0] s;
    logic c, z, n, o;
    ua = int'(a);
    ub = int'(b);
    us = ua + ub;
    s  = us[W-1:0];
    c  = (us >= 2**W);
    z  = (s == '0);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    ts = sa + sb;
    o  = (ts >= 2**(W-1)) || (ts < -(2**(W-1)));
    n  = (ts < 0);
    return {s, c, z, n, o};
  endfunction

  function automatic logic [BW-1:0] exp_bundle();
    return {exp_gnt, exp_done, exp_busy, vis};
  endfunction

  task automatic model_reset();
    m_done_cyc = -1;
    m_last     = 1'b1;
    m_id       = 1'b0;
    pend       = '0;
    vis        = '0;
  endtask

  task automatic model_eval();
    if (cyc == m_done_cyc) vis = pend;
    exp_done = (cyc == m_done_cyc) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
    exp_busy = (cyc < m_done_cyc);
    exp_gnt  = 2'b00;
    if (cyc >= m_done_cyc) begin
      if (req == 2'b11) exp_gnt = m_last ? 2'b01 : 2'b10;
      else              exp_gnt = req;
    end
  endtask

  task automatic model_step();
    if (exp_gnt != 2'b00) begin
      m_id       = exp_gnt[1];
      m_last     = m_id;
      pend       = m_id ? ref_add(a1, b1) : ref_add(a0, b0);
      m_done_cyc = cyc + W + 1;
    end
    cyc++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_ops();
    a0 = W'($urandom);
    b0 = W'($urandom);
    a1 = W'($urandom);
    b1 = W'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    req  = 2'b00;
    rand_ops();
    #2;
    rstn = 1'b0;
    req  = 2'b11;
    model_reset();
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_async obs=%h exp=%h", obs, {BW{1'b0}});
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_held obs=%h exp=%h", obs, {BW{1'b0}});
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] a, b, s;
    logic         c, z, n, o;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[4];
    int   gcyc, dcyc;
    tbl[0] = '{1'b0, 6'd5,  6'd3,  6'd8,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 6'd31, 6'd1,  6'd32, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 6'd32, 6'd32, 6'd0,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 6'd63, 6'd1,  6'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    foreach (tbl[v]) begin
      gcyc = -1;
      dcyc = -1;
      rand_ops();
      if (tbl[v].id) begin a1 = tbl[v].a; b1 = tbl[v].b; req = 2'b10; end
      else           begin a0 = tbl[v].a; b0 = tbl[v].b; req = 2'b01; end
      for (int k = 0; k < 20 && dcyc < 0; k++) begin
        if (gcyc >= 0) begin
          req = 2'b00;
          rand_ops();
        end
        #1;
        model_eval();
        checks++;
        if (obs !== exp_bundle()) begin
          errors++;
          $display("FAIL directed%0d cyc=%0d obs=%h exp=%h", v, cyc, obs, exp_bundle());
        end
        if (gnt[tbl[v].id] && gcyc < 0) gcyc = cyc;
        if (done[tbl[v].id]) begin
          dcyc = cyc;
          checks++;
          if (dcyc - gcyc !== W + 1) begin
            errors++;
            $display("FAIL latency%0d got=%0d exp=%0d", v, dcyc - gcyc, W + 1);
          end
          checks++;
          if ({done, sum, cout, zero, neg, ovf} !==
              {(tbl[v].id ? 2'b10 : 2'b01), tbl[v].s, tbl[v].c, tbl[v].z, tbl[v].n, tbl[v].o}) begin
            errors++;
            $display("FAIL result%0d got done=%b sum=%0d c=%b z=%b n=%b o=%b exp sum=%0d c=%b z=%b n=%b o=%b",
                     v, done, sum, cout, zero, neg, ovf,
                     tbl[v].s, tbl[v].c, tbl[v].z, tbl[v].n, tbl[v].o);
          end
        end
        next_cycle();
      end
      if (dcyc < 0) begin
        errors++;
        checks++;
        $display("FAIL directed%0d_timeout got=no_done exp=done", v);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq[$];
    logic [1:0] rr_exp[4];
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 4 * (W + 1) + W + 2; k++) begin
      if (k == 4 * (W + 1)) req = 2'b00;
      rand_ops();
      #1;
      model_eval();
      checks++;
      if (obs !== exp_bundle()) begin
        errors++;
        $display("FAIL rr cyc=%0d obs=%h exp=%h", cyc, obs, exp_bundle());
      end
      if (gnt != 2'b00) begin
        if (seq.size() > 0) begin
          checks++;
          if (done !== {gnt[0], gnt[1]}) begin
            errors++;
            $display("FAIL rr_overlap got done=%b exp=%b", done, {gnt[0], gnt[1]});
          end
        end
        seq.push_back(gnt);
      end
      next_cycle();
    end
    checks++;
    if (seq.size() != 4) begin
      errors++;
      $display("FAIL rr_count got=%0d exp=4", seq.size());
    end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== rr_exp[i]) begin
        errors++;
        $display("FAIL rr_order%0d got=%b exp=%b", i, seq[i], rr_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req = 2'b01;
    for (int k = 0; k <= 4; k++) begin
      if (k == 1) req = 2'b00;
      if (k > 0) rand_ops();
      #1;
      model_eval();
      checks++;
      if (obs !== exp_bundle()) begin
        errors++;
        $display("FAIL midrst_pre cyc=%0d obs=%h exp=%h", cyc, obs, exp_bundle());
      end
      if (k < 4) next_cycle();
    end
    req = 2'b01;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL midrst_async obs=%h exp=%h", obs, {BW{1'b0}});
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL midrst_no_done obs=%h exp=%h", obs, {BW{1'b0}});
    end
    @(negedge clk);
    rstn = 1'b1;
    req  = 2'b11;
    #1;
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL midrst_first_gnt got=%b exp=01", gnt);
    end
    for (int k = 0; k < W + 2; k++) begin
      if (k == 1) req = 2'b00;
      if (k > 0) #1;
      model_eval();
      checks++;
      if (obs !== exp_bundle()) begin
        errors++;
        $display("FAIL midrst_post cyc=%0d obs=%h exp=%h", cyc, obs, exp_bundle());
      end
      next_cycle();
      rand_ops();
    end
  endtask

  task automatic test_pulse_during_run();
    int g1_seen = 0;
    req = 2'b01;
    rand_ops();
    for (int k = 0; k < W + 3; k++) begin
      req = (k == 0) ? 2'b01 : ((k == 2 || k == 3) ? 2'b10 : 2'b00);
      #1;
      model_eval();
      checks++;
      if (obs !== exp_bundle()) begin
        errors++;
        $display("FAIL pulse cyc=%0d obs=%h exp=%h", cyc, obs, exp_bundle());
      end
      if (gnt[1]) g1_seen++;
      next_cycle();
      rand_ops();
    end
    checks++;
    if (g1_seen != 0) begin
      errors++;
      $display("FAIL pulse_gnt1 got=%0d exp=0", g1_seen);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req = 2'($urandom_range(0, 3));
      rand_ops();
      #1;
      model_eval();
      checks++;
      if (obs !== exp_bundle()) begin
        errors++;
        $display("FAIL random cyc=%0d req=%b obs=%h exp=%h", cyc, req, obs, exp_bundle());
      end
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_reset_mid_run();
    test_pulse_during_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
